// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the round-robin FIFO controller: default widths and
// read-side state encoding.
package fifo_ctrl_pkg;

    localparam int unsigned DwDefault   = 8;
    localparam int unsigned CntWDefault = 8;
    localparam int unsigned HiWmDefault = 7;

    localparam logic StIdle  = 1'b0;
    localparam logic StValid = 1'b1;

endpackage

// File: rtl/fifo_rr_ctrl_if.sv
// Handshake bundle around the FIFO controller: two producers, the FIFO ports
// and one consumer. The master modport is the controller's view.
interface fifo_rr_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DW = DwDefault
);
    logic          s0_valid;
    logic [DW-1:0] s0_data;
    logic          s0_ready;
    logic          s1_valid;
    logic [DW-1:0] s1_data;
    logic          s1_ready;

    logic          fifo_wr_en;
    logic [DW-1:0] fifo_data_in;
    logic          fifo_full;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_empty;
    logic [3:0]    fifo_words;

    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    modport master (
        input  s0_valid, s0_data, s1_valid, s1_data,
        output s0_ready, s1_ready,
        output fifo_wr_en, fifo_data_in, fifo_rd_en,
        input  fifo_full, fifo_data_out, fifo_empty, fifo_words,
        output m_valid, m_data,
        input  m_ready
    );

    modport slave (
        output s0_valid, s0_data, s1_valid, s1_data,
        input  s0_ready, s1_ready,
        input  fifo_wr_en, fifo_data_in, fifo_rd_en,
        output fifo_full, fifo_data_out, fifo_empty, fifo_words,
        input  m_valid, m_data,
        output m_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The last-grant pointer only moves on an
// accepted transfer, so a stalled winner keeps its grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        last_d = (accept_i && (gnt_o != 2'b00)) ? gnt_o[1] : last_q;
    end

    // Resets to 1 so that source 0 wins the first contested cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fifo_rr_ctrl.sv
// FIFO controller: round-robin write arbitration of two producers, a read-side
// FSM turning the registered FIFO read port into valid/ready, and debug counters.
module fifo_rr_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DW    = DwDefault,
    parameter int unsigned HI_WM = HiWmDefault,
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_rr_ctrl_if.master   bus,
    output logic [CNT_W-1:0] cnt_s0,
    output logic [CNT_W-1:0] cnt_s1
);

    localparam logic [3:0]       HiWm   = 4'(HI_WM);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             wr_ok;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             accept;
    logic [DW-1:0]    wr_data;
    logic [CNT_W-1:0] cnt_s0_q, cnt_s0_d, cnt_s1_q, cnt_s1_d;
    logic             state_q, state_d;
    logic             rd_en;

    assign wr_ok  = !bus.fifo_full && (bus.fifo_words < HiWm);
    assign req    = {bus.s1_valid, bus.s0_valid};
    assign accept = (req != 2'b00) && wr_ok;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign wr_data          = gnt[1] ? bus.s1_data : bus.s0_data;
    assign bus.fifo_data_in = wr_data;
    // Outputs are gated by rst_n so they drop the instant reset asserts.
    assign bus.fifo_wr_en   = rst_n && accept;
    assign bus.s0_ready     = rst_n && gnt[0] && wr_ok;
    assign bus.s1_ready     = rst_n && gnt[1] && wr_ok;

    always_comb begin
        cnt_s0_d = cnt_s0_q;
        cnt_s1_d = cnt_s1_q;
        if (accept && gnt[0] && (cnt_s0_q != CntMax)) cnt_s0_d = cnt_s0_q + 1'b1;
        if (accept && gnt[1] && (cnt_s1_q != CntMax)) cnt_s1_d = cnt_s1_q + 1'b1;
    end

    assign cnt_s0 = cnt_s0_q;
    assign cnt_s1 = cnt_s1_q;

    // The FIFO's data_out register doubles as the output holding register.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (!bus.fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (bus.m_ready) begin
                    if (!bus.fifo_empty) begin
                        rd_en = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.fifo_rd_en = rst_n && rd_en;
    assign bus.m_valid    = rst_n && (state_q == StValid);
    assign bus.m_data     = bus.fifo_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_s0_q <= '0;
            cnt_s1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_s0_q <= cnt_s0_d;
            cnt_s1_q <= cnt_s1_d;
        end
    end

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Bench for fifo_rr_ctrl: behavioural 8-deep FIFO, random producers/consumer,
// and a queue-based reference model of arbitration, ordering and counters.
module tb_fifo_rr_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_rr_ctrl_if #(.DW(8)) bus ();
    logic [7:0] cnt_s0, cnt_s1;

    fifo_rr_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .cnt_s0 (cnt_s0),
        .cnt_s1 (cnt_s1)
    );

    // Behavioural FIFO: depth 8, synchronous clear, registered read data.
    logic [7:0] f_mem [8];
    logic [2:0] f_wp, f_rp;
    logic [3:0] f_words;
    logic [7:0] f_dout;
    wire        f_w = bus.fifo_wr_en && (f_words != 4'd8);
    wire        f_r = bus.fifo_rd_en && (f_words != 4'd0);

    always @(posedge clk) begin
        if (!rst_n) begin
            f_wp    <= '0;
            f_rp    <= '0;
            f_words <= '0;
        end else begin
            if (f_w) begin
                f_mem[f_wp] <= bus.fifo_data_in;
                f_wp        <= f_wp + 3'd1;
            end
            if (f_r) begin
                f_dout <= f_mem[f_rp];
                f_rp   <= f_rp + 3'd1;
            end
            f_words <= f_words + 4'(f_w) - 4'(f_r);
        end
    end

    assign bus.fifo_full     = (f_words == 4'd8);
    assign bus.fifo_empty    = (f_words == 4'd0);
    assign bus.fifo_words    = f_words;
    assign bus.fifo_data_out = f_dout;

    // Producers and consumer.
    logic [1:0] pend;
    logic [7:0] pdat [2];
    int         prob [2];
    int         seq  [2];
    bit         pat_mode;
    logic       mrdy;

    assign bus.s0_valid = pend[0];
    assign bus.s0_data  = pdat[0];
    assign bus.s1_valid = pend[1];
    assign bus.s1_data  = pdat[1];
    assign bus.m_ready  = mrdy;

    // Reference model state.
    int         m_last;
    int         m_cnt   [2];
    int         acc_cnt [2];
    logic [7:0] exp_q [$];
    logic [7:0] out_log [$];
    int         hs_count;
    bit         prev_stall;
    logic [7:0] prev_data;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pend       = 2'b00;
        m_last     = 1;
        m_cnt[0]   = 0;
        m_cnt[1]   = 0;
        exp_q.delete();
        prev_stall = 1'b0;
    endtask

    // Asserts reset between edges, checks the forced outputs, clears the FIFO.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_m_valid", bus.m_valid, 0);
        check_eq("rst_rd_en", bus.fifo_rd_en, 0);
        check_eq("rst_wr_en", bus.fifo_wr_en, 0);
        check_eq("rst_s0_ready", bus.s0_ready, 0);
        check_eq("rst_s1_ready", bus.s1_ready, 0);
        check_eq("rst_cnt_s0", cnt_s0, 0);
        check_eq("rst_cnt_s1", cnt_s1, 0);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic cycle();
        logic       wr_ok;
        logic       acc;
        int         g;
        logic [8:0] e;
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && ($urandom_range(99) < prob[i])) begin
                pend[i] = 1'b1;
                pdat[i] = pat_mode ? ((i == 0 ? 8'hA0 : 8'hB0) + 8'(seq[i])) : 8'($urandom);
                seq[i]++;
            end
        end
        @(negedge clk);
        wr_ok = (f_words != 4'd8) && (f_words < 4'd7);
        if (pend == 2'b11) g = (m_last == 1) ? 0 : 1;
        else g = pend[1] ? 1 : 0;
        acc = (pend != 2'b00) && wr_ok;
        check_eq("s0_ready", bus.s0_ready, 32'(acc && g == 0));
        check_eq("s1_ready", bus.s1_ready, 32'(acc && g == 1));
        check_eq("wr_en", bus.fifo_wr_en, 32'(acc));
        if (acc) check_eq("wr_data", bus.fifo_data_in, pdat[g]);
        check_eq("rd_while_empty", 32'(bus.fifo_rd_en && f_words == 4'd0), 0);
        check_eq("cnt_s0", cnt_s0, m_cnt[0]);
        check_eq("cnt_s1", cnt_s1, m_cnt[1]);
        if (prev_stall) begin
            check_eq("stall_valid", bus.m_valid, 1);
            check_eq("stall_data", bus.m_data, prev_data);
        end
        if (bus.m_valid && mrdy) begin
            e = (exp_q.size() > 0) ? {1'b1, exp_q.pop_front()} : 9'h0;
            check_eq("out_data", {1'b1, bus.m_data}, e);
            out_log.push_back(bus.m_data);
            hs_count++;
        end
        prev_stall = bus.m_valid && !mrdy;
        prev_data  = bus.m_data;
        @(posedge clk);
        #1;
        if (acc) begin
            exp_q.push_back(pdat[g]);
            pend[g] = 1'b0;
            m_last  = g;
            if (m_cnt[g] < 255) m_cnt[g]++;
            acc_cnt[g]++;
        end
    endtask

    task automatic drain();
        prob[0] = 0;
        prob[1] = 0;
        mrdy    = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (pend == 2'b00 && exp_q.size() == 0 && !bus.m_valid) break;
            cycle();
        end
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int start;
        rst_n    = 1'b1;
        pend     = 2'b01;
        pdat[0]  = 8'h11;
        pdat[1]  = 8'h00;
        prob[0]  = 0;
        prob[1]  = 0;
        seq[0]   = 0;
        seq[1]   = 0;
        pat_mode = 1'b0;
        mrdy     = 1'b0;
        hs_count = 0;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        do_reset();

        // 1: single word latency.
        pend    = 2'b01;
        pdat[0] = 8'h11;
        cycle();
        check_eq("t1_mvalid_early", bus.m_valid, 0);
        check_eq("t1_rd_en", bus.fifo_rd_en, 1);
        cycle();
        check_eq("t1_mvalid", bus.m_valid, 1);
        check_eq("t1_mdata", bus.m_data, 8'h11);
        drain();

        // 2: contested round-robin ordering from reset.
        do_reset();
        out_log.delete();
        pat_mode = 1'b1;
        prob[0]  = 100;
        prob[1]  = 100;
        mrdy     = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
        drain();
        pat_mode = 1'b0;
        check_eq("t2_count", 32'(out_log.size() >= 4), 1);
        if (out_log.size() >= 4) begin
            check_eq("t2_w0", out_log[0], 8'hA0);
            check_eq("t2_w1", out_log[1], 8'hB0);
            check_eq("t2_w2", out_log[2], 8'hA1);
            check_eq("t2_w3", out_log[3], 8'hB1);
        end

        // 3: fill to the watermark with the consumer stalled, then burst out.
        prob[0] = 100;
        prob[1] = 100;
        mrdy    = 1'b0;
        for (int k = 0; k < 20; k++) cycle();
        check_eq("t3_words", f_words, 7);
        check_eq("t3_wr_en", bus.fifo_wr_en, 0);
        check_eq("t3_s0_ready", bus.s0_ready, 0);
        check_eq("t3_s1_ready", bus.s1_ready, 0);
        prob[0] = 0;
        prob[1] = 0;
        mrdy    = 1'b1;
        start   = hs_count;
        for (int k = 0; k < 8; k++) cycle();
        check_eq("t3_burst", hs_count - start, 8);
        drain();

        // 4: consumer ready toggling every cycle.
        prob[0] = 60;
        prob[1] = 60;
        for (int k = 0; k < 200; k++) begin
            mrdy = k[0];
            cycle();
        end
        drain();

        // 5: counter saturation.
        prob[0] = 100;
        prob[1] = 0;
        mrdy    = 1'b1;
        start   = acc_cnt[0];
        for (int k = 0; k < 1000; k++) begin
            if (acc_cnt[0] - start >= 300) break;
            cycle();
        end
        check_eq("t5_accepts", 32'(acc_cnt[0] - start >= 300), 1);
        check_eq("t5_sat", cnt_s0, 255);
        drain();

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            if (k % 50 == 0) begin
                prob[0] = $urandom_range(100);
                prob[1] = $urandom_range(100);
            end
            mrdy = ($urandom_range(99) < 70);
            cycle();
        end

        // 6: asynchronous reset mid-stream, then a fresh word.
        prob[0] = 100;
        prob[1] = 100;
        mrdy    = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        do_reset();
        prob[0] = 0;
        prob[1] = 0;
        pend    = 2'b01;
        pdat[0] = 8'h5A;
        out_log.delete();
        for (int k = 0; k < 10; k++) begin
            if (out_log.size() > 0) break;
            cycle();
        end
        check_eq("t6_delivered", out_log.size(), 1);
        if (out_log.size() > 0) check_eq("t6_data", out_log[0], 8'h5A);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
